// File: rtl/tile_mem_noc_ctrl.sv
// tile_mem_noc_ctrl
// NoC-side command engine in front of the tile's banked SRAM. It takes 64-bit
// command headers and write-data beats from the NoC port. It runs single or
// burst word reads and writes against one bank. It returns read data and
// write acknowledges through a small response FIFO that the consumer can stall.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   cmd_data/valid/ready     command header or write-data beat (valid/ready)
//   rsp_data/valid/ready     response word (valid/ready), with
//   rsp_last, rsp_err        end-of-command and error flags
//   mem_enable               one-hot bank enable (zero when idle)
//   mem_write_en             write strobe, qualified by mem_enable
//   mem_addr, mem_wdata      byte address (word aligned) and write data
//   mem_rdata                flattened per-bank read data, 1-cycle latency
//
// Header: [63:62] op (0 NOP, 1 READ, 2 WRITE, 3 reserved), [61:60] bank,
//         [59:50] word address, [49:46] length-1, [45:0] ignored.
//
// Build option: define TILE_MEM_NOC_ERR_EN so that op 3 returns a single error
// response. When it is not defined, op 3 is consumed as a NOP and rsp_err is 0.
module tile_mem_noc_ctrl #(
  parameter int BANKS      = 4,
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 64,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [63:0]                 cmd_data,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  output logic [DATA_WIDTH-1:0]       rsp_data,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic                        rsp_last,
  output logic                        rsp_err,
  output logic [BANKS-1:0]            mem_enable,
  output logic                        mem_write_en,
  output logic [ADDR_WIDTH-1:0]       mem_addr,
  output logic [DATA_WIDTH-1:0]       mem_wdata,
  input  logic [BANKS*DATA_WIDTH-1:0] mem_rdata
);

  localparam int WORD_W = ADDR_WIDTH - 3;
  localparam int PTR_W  = $clog2(RSP_DEPTH);
`ifdef TILE_MEM_NOC_ERR_EN
  localparam int ENTRY_W = DATA_WIDTH + 2;  // {data, last, err}
`else
  localparam int ENTRY_W = DATA_WIDTH + 1;  // {data, last}
`endif
  localparam logic [PTR_W:0] DEPTH = (PTR_W + 1)'(RSP_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, ERR = 2'd3} state_t;

  state_t state_reg, state_next;

  logic [17:0]       hdr_reg;        // header[63:46]
  logic [WORD_W-1:0] word_reg;       // current word address
  logic [4:0]        cnt_reg;        // words issued / beats written so far
  logic              pend_reg;       // a read was issued last cycle
  logic              pend_last_reg;  // ... and it was the final word
  logic              live_reg;       // holds cmd_ready low for the first cycle after reset

  logic [ENTRY_W-1:0] fifo_mem [RSP_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]     count_reg;

  logic [1:0]            bank_sel;
  logic [3:0]            len_m1;
  logic [4:0]            len;
  logic                  empty, full;
  logic [PTR_W:0]        free;
  logic                  hdr_fire, wr_fire, issue, access, pop;
  logic                  push, push_last;
  logic [DATA_WIDTH-1:0] push_data, ack_word;
  logic [ENTRY_W-1:0]    push_entry;
  logic [DATA_WIDTH-1:0] bank_rdata [BANKS];
`ifdef TILE_MEM_NOC_ERR_EN
  logic                  push_err;
`endif

  assign bank_sel = hdr_reg[15:14];
  assign len_m1   = hdr_reg[3:0];
  assign len      = {1'b0, len_m1} + 5'd1;
  assign ack_word = {hdr_reg, {(DATA_WIDTH - 18){1'b0}}};

  assign empty = (count_reg == '0);
  assign full  = (count_reg == DEPTH);
  assign free  = DEPTH - count_reg;

  always_comb begin
    cmd_ready = 1'b0;
    if (live_reg) begin
      case (state_reg)
        IDLE:    cmd_ready = 1'b1;
        WR:      cmd_ready = !full;
        default: cmd_ready = 1'b0;
      endcase
    end
  end

  assign hdr_fire = cmd_valid && cmd_ready && (state_reg == IDLE);
  assign wr_fire  = cmd_valid && cmd_ready && (state_reg == WR);
  // A read may be issued only if the FIFO still has room after the read that
  // is already in flight has landed. This keeps the FIFO from overflowing.
  assign issue    = (state_reg == RD) && (cnt_reg < len) &&
                    (free > {{PTR_W{1'b0}}, pend_reg});
  assign access   = issue || wr_fire;
  assign pop      = !empty && rsp_ready;

  for (genvar gi = 0; gi < BANKS; gi++) begin : g_bank
    assign bank_rdata[gi] = mem_rdata[gi*DATA_WIDTH +: DATA_WIDTH];
    assign mem_enable[gi] = access && (bank_sel == 2'(gi));
  end

  assign mem_write_en = wr_fire;
  assign mem_addr     = access ? {word_reg, 3'b000} : '0;
  assign mem_wdata    = wr_fire ? cmd_data : '0;

  always_comb begin
    state_next = state_reg;
    push       = 1'b0;
    push_data  = ack_word;
    push_last  = 1'b1;
`ifdef TILE_MEM_NOC_ERR_EN
    push_err   = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (hdr_fire) begin
          case (cmd_data[63:62])
            2'd1:    state_next = RD;
            2'd2:    state_next = WR;
`ifdef TILE_MEM_NOC_ERR_EN
            2'd3:    state_next = ERR;
`endif
            default: state_next = IDLE;
          endcase
        end
      end
      RD: begin
        if (pend_reg) begin
          push      = 1'b1;
          push_data = bank_rdata[bank_sel];
          push_last = pend_last_reg;
          if (cnt_reg == len) state_next = IDLE;  // final capture lands now
        end
      end
      WR: begin
        if (wr_fire && (cnt_reg == {1'b0, len_m1})) begin
          push       = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
`ifdef TILE_MEM_NOC_ERR_EN
        if (!full) begin
          push       = 1'b1;
          push_err   = 1'b1;
          state_next = IDLE;
        end
`else
        state_next = IDLE;
`endif
      end
    endcase
  end

`ifdef TILE_MEM_NOC_ERR_EN
  assign push_entry = {push_data, push_last, push_err};
  assign rsp_err    = !empty && fifo_mem[rd_ptr_reg][0];
`else
  assign push_entry = {push_data, push_last};
  assign rsp_err    = 1'b0;
`endif
  assign rsp_valid = !empty;
  assign rsp_data  = empty ? '0 : fifo_mem[rd_ptr_reg][ENTRY_W-1 -: DATA_WIDTH];
  assign rsp_last  = !empty && fifo_mem[rd_ptr_reg][ENTRY_W-DATA_WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      hdr_reg       <= '0;
      word_reg      <= '0;
      cnt_reg       <= '0;
      pend_reg      <= 1'b0;
      pend_last_reg <= 1'b0;
      live_reg      <= 1'b0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
    end else begin
      state_reg <= state_next;
      live_reg  <= 1'b1;
      if (hdr_fire) begin
        hdr_reg  <= cmd_data[63:46];
        word_reg <= cmd_data[50 +: WORD_W];
        cnt_reg  <= '0;
      end else if (access) begin
        word_reg <= word_reg + WORD_W'(1);  // wraps within the bank
        cnt_reg  <= cnt_reg + 5'd1;
      end
      pend_reg      <= issue;
      pend_last_reg <= issue && (cnt_reg == {1'b0, len_m1});
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      if (push && !pop)      count_reg <= count_reg + (PTR_W + 1)'(1);
      else if (!push && pop) count_reg <= count_reg - (PTR_W + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= push_entry;
  end

endmodule

// File: tb/tb_tile_mem_noc_ctrl.sv
// Testbench for tile_mem_noc_ctrl. The stimulus pushes expected responses and
// expected SRAM accesses into queues. Two monitors pop those queues and compare
// whenever the DUT presents a response or a bank access.
module tb_tile_mem_noc_ctrl;
  localparam int BANKS = 4;
  localparam int AW    = 13;
  localparam int DW    = 64;
  localparam int DEPTH = 4;
  localparam logic [45:0] JUNK = 46'h2A5A5A5A5A5;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic [63:0]        cmd_data = '0;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [DW-1:0]      rsp_data;
  logic               rsp_valid;
  logic               rsp_ready = 1'b1;
  logic               rsp_last;
  logic               rsp_err;
  logic [BANKS-1:0]   mem_enable;
  logic               mem_write_en;
  logic [AW-1:0]      mem_addr;
  logic [DW-1:0]      mem_wdata;
  logic [BANKS*DW-1:0] mem_rdata;

  tile_mem_noc_ctrl #(.BANKS(BANKS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RSP_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_last(rsp_last), .rsp_err(rsp_err),
    .mem_enable(mem_enable), .mem_write_en(mem_write_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // SRAM model: one-cycle synchronous read per bank
  logic [63:0] sram   [BANKS][1024];
  logic [63:0] bank_q [BANKS];
  always @(posedge clk) begin
    for (int b = 0; b < BANKS; b++) begin
      if (mem_enable[b]) begin
        if (mem_write_en) sram[b][mem_addr[12:3]] <= mem_wdata;
        else              bank_q[b] <= sram[b][mem_addr[12:3]];
      end
    end
  end
  for (genvar gi = 0; gi < BANKS; gi++) begin : g_rd
    assign mem_rdata[gi*DW +: DW] = bank_q[gi];
  end

  typedef struct packed { logic [63:0] data; logic last; logic err; } rsp_t;
  typedef struct packed { logic [3:0] en; logic we; logic [12:0] addr; logic [63:0] wdata; } acc_t;
  rsp_t rsp_q[$];
  acc_t acc_q[$];
  logic [63:0] shadow [BANKS][1024];

  int asserts = 0;
  int fails = 0;
  int issues_seen = 0;
  int rsp_seen = 0;

  // Response monitor
  logic prev_hold = 1'b0;
  rsp_t prev_rsp = '0;
  always @(negedge clk) begin
    rsp_t act, exp;
    act = rsp_t'({rsp_data, rsp_last, rsp_err});
    if (rst_n) begin
      if (rsp_valid && prev_hold) begin
        asserts++;
        if (act !== prev_rsp) begin
          fails++;
          $display("FAIL rsp_stable: got %h required %h", act, prev_rsp);
        end
      end
      prev_hold = rsp_valid && !rsp_ready;
      prev_rsp  = act;
      if (rsp_valid && rsp_ready) begin
        rsp_seen++;
        asserts++;
        if (rsp_q.size() == 0) begin
          fails++;
          $display("FAIL rsp_unexpected: got data=%h last=%b err=%b required none", rsp_data, rsp_last, rsp_err);
        end else begin
          exp = rsp_q.pop_front();
          if (act !== exp) begin
            fails++;
            $display("FAIL rsp_word: got data=%h last=%b err=%b required data=%h last=%b err=%b",
                     act.data, act.last, act.err, exp.data, exp.last, exp.err);
          end else begin
            $display("rsp   data=%h last=%b err=%b", act.data, act.last, act.err);
          end
        end
      end
    end
  end

  // Bank-access monitor
  always @(negedge clk) begin
    acc_t act, exp;
    if (mem_enable != '0) begin
      act = acc_t'({mem_enable, mem_write_en, mem_addr, mem_wdata});
      issues_seen++;
      asserts++;
      if (acc_q.size() == 0) begin
        fails++;
        $display("FAIL mem_unexpected: got en=%b we=%b addr=%h required none", act.en, act.we, act.addr);
      end else begin
        exp = acc_q.pop_front();
        if (!act.we) act.wdata = '0;  // write data is don't-care on reads
        if (act !== exp) begin
          fails++;
          $display("FAIL mem_access: got en=%b we=%b addr=%h wd=%h required en=%b we=%b addr=%h wd=%h",
                   act.en, act.we, act.addr, act.wdata, exp.en, exp.we, exp.addr, exp.wdata);
        end else begin
          $display("mem   en=%b we=%b addr=%h wd=%h", act.en, act.we, act.addr, act.wdata);
        end
      end
    end
  end

  function automatic logic [63:0] hdr(input logic [1:0] op, input int bank, input int w, input int len);
    logic [9:0] w10;
    logic [1:0] b2;
    logic [3:0] l4;
    w10 = w[9:0];
    b2  = bank[1:0];
    l4  = 4'(len - 1);
    return {op, b2, w10, l4, 46'd0};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string name, input logic ready_exp);
    logic [148:0] outs;
    outs = {rsp_data, rsp_valid, rsp_last, rsp_err, mem_enable, mem_write_en, mem_addr, mem_wdata};
    asserts++;
    if (outs !== '0 || cmd_ready !== ready_exp) begin
      fails++;
      $display("FAIL %s: got outputs=%h cmd_ready=%b required 0 and cmd_ready=%b", name, outs, cmd_ready, ready_exp);
    end
  endtask

  task automatic put(input logic [63:0] w);
    int n;
    logic got;
    n = 0;
    got = 1'b0;
    cmd_data  = w;
    cmd_valid = 1'b1;
    while (!got && n < 200) begin
      @(negedge clk);
      got = cmd_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!got) begin
      asserts++;
      fails++;
      $display("FAIL cmd_accept: got no transfer in 200 cycles required transfer");
    end
    cmd_valid = 1'b0;
    cmd_data  = 64'hBAD0_BAD0_BAD0_BAD0;
  endtask

  task automatic do_write(input int bank, input int w, input int len, input logic [63:0] base, input int gap);
    logic [63:0] h;
    h = hdr(2'd2, bank, w, len);
    for (int i = 0; i < len; i++) begin
      int a;
      a = (w + i) % 1024;
      acc_q.push_back(acc_t'({4'(1 << bank), 1'b1, 13'(a * 8), base + 64'(i)}));
      shadow[bank][a] = base + 64'(i);
    end
    rsp_q.push_back(rsp_t'({h, 1'b1, 1'b0}));
    put(h | {18'd0, JUNK});
    for (int i = 0; i < len; i++) begin
      put(base + 64'(i));
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic do_read(input int bank, input int w, input int len);
    for (int i = 0; i < len; i++) begin
      int a;
      a = (w + i) % 1024;
      acc_q.push_back(acc_t'({4'(1 << bank), 1'b0, 13'(a * 8), 64'd0}));
      rsp_q.push_back(rsp_t'({shadow[bank][a], (i == len - 1), 1'b0}));
    end
    put(hdr(2'd1, bank, w, len) | {18'd0, JUNK});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((rsp_q.size() != 0 || acc_q.size() != 0) && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    asserts++;
    if (rsp_q.size() != 0 || acc_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d responses and %0d accesses pending required 0", rsp_q.size(), acc_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, snap, snap_rsp;
    #1 rst_n = 1'b0;
    #7 check_zero("reset_outputs", 1'b0);
    #14 rst_n = 1'b1;
    #1 check_zero("ready_before_edge", 1'b0);
    @(negedge clk);
    check_zero("ready_after_edge", 1'b1);
    @(posedge clk);
    #1;

    // single write, then read back
    do_write(2, 5, 1, 64'hDEADBEEF_00000001, 0);
    drain();
    do_read(2, 5, 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 10);
    check("read_latency", 64'(n), 64'd3);
    drain();

    // burst across the 1023->0 wrap
    do_write(0, 1022, 4, 64'hA5A5_0000_0000_0100, 1);
    drain();
    do_read(0, 1022, 4);
    drain();

    // 16-word read with a stalled consumer
    do_write(1, 100, 16, 64'h1111_2222_0000_0000, 0);
    drain();
    rsp_ready = 1'b0;
    snap = issues_seen;
    do_read(1, 100, 16);
    repeat (20) @(posedge clk);
    #1;
    check("stall_issues", 64'(issues_seen - snap), 64'(DEPTH));
    check("stall_valid", {63'd0, rsp_valid}, 64'd1);
    rsp_ready = 1'b1;
    drain();

    // write with idle gaps between beats
    do_write(3, 10, 3, 64'hC0DE_0000_0000_0A00, 2);
    drain();
    do_read(3, 10, 3);
    drain();

    // reserved op and NOP
`ifdef TILE_MEM_NOC_ERR_EN
    rsp_q.push_back(rsp_t'({hdr(2'd3, 1, 7, 2), 1'b1, 1'b1}));
`endif
    put(hdr(2'd3, 1, 7, 2) | {18'd0, JUNK});
    do_read(2, 5, 1);
    drain();
    put(hdr(2'd0, 0, 0, 1) | {18'd0, JUNK});
    do_read(0, 1023, 1);
    drain();

    // reset in the middle of a read burst
    rsp_ready = 1'b0;
    do_read(1, 100, 16);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("reset_midburst", 1'b0);
    rsp_q.delete();
    acc_q.delete();
    snap_rsp = rsp_seen;
    snap = issues_seen;
    @(posedge clk);
    #2 rst_n = 1'b1;
    rsp_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("no_rsp_after_reset", 64'(rsp_seen - snap_rsp), 64'd0);
    check("no_access_after_reset", 64'(issues_seen - snap), 64'd0);
    do_read(0, 1022, 2);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule

// File: doc/tile_mem_noc_ctrl.md
Name: tile_mem_noc_ctrl

Overview:
NoC-side command engine sitting directly upstream of the tile's 4-bank SRAM.
- Accepts 64-bit memory commands (plus write-data beats) from the tile NoC port.
- Executes single or burst word reads/writes against one SRAM bank.
- Returns read data and write acknowledges on a back-pressurable response channel.
- Replaces the tile memory's echo-only NoC path.

Parameters:
BANKS, 4, number of SRAM banks
ADDR_WIDTH, 13, byte address width per bank (8KB)
DATA_WIDTH, 64, word width
RSP_DEPTH, 4, response FIFO entries (power of two, >=2)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
cmd_data  input  64  command header or write-data beat
cmd_valid  input  1  cmd_data valid
cmd_ready  output  1  engine accepts cmd_data this cycle
rsp_data  output  64  read data or write-ack word
rsp_valid  output  1  response valid
rsp_ready  input  1  consumer accepts response
rsp_last  output  1  final beat of a command's response
rsp_err  output  1  error response
mem_enable  output  BANKS  one-hot bank enable
mem_write_en  output  1  write strobe (qualified by mem_enable)
mem_addr  output  ADDR_WIDTH  byte address, bits [2:0] always 0
mem_wdata  output  DATA_WIDTH  write data
mem_rdata  input  BANKS*DATA_WIDTH  flattened bank read data, 1-cycle synchronous latency

Behaviour:
- Reset: rst_n asynchronous, active-low; clock clk. All outputs 0 during and after reset; FSM to IDLE; FIFO emptied; in-flight reads discarded.
- Header fields:
  - [63:62] op: 0=NOP, 1=READ, 2=WRITE, 3=reserved.
  - [61:60] bank.
  - [59:50] word address W.
  - [49:46] LEN-1, giving 1..16 words.
  - [45:0] ignored.
- mem_addr = {W_cur, 3'b000}. W_cur increments per word and wraps 1023->0 within the same bank.
- A transfer occurs when valid && ready on either channel.
- FSM states:
  - IDLE:
    - cmd_ready=1.
    - Header transfer: NOP -> stay IDLE, no response. READ -> RD. WRITE -> WR. op 3 -> see Optional Feature.
  - RD:
    - cmd_ready=0.
    - Issue one read per cycle (mem_enable[bank]=1, mem_write_en=0) only if FIFO free entries > reads in flight.
    - Capture rdata from the selected bank the cycle after issue and push it to the FIFO; rsp_last=1 on word LEN.
    - After the last issue -> IDLE, once the final capture has been pushed.
  - WR:
    - cmd_ready=1 only while the FIFO is not full.
    - Each data transfer writes that cycle: mem_enable[bank]=1, mem_write_en=1, mem_wdata=cmd_data.
    - After LEN beats, push ack {header[63:46], 46'b0} with rsp_last=1, rsp_err=0 -> IDLE.
- Response FIFO:
  - RSP_DEPTH entries, each 66 bits (data, last, err).
  - rsp_valid = !empty; push and pop in the same cycle are allowed when full.
  - Never overflows: issue is throttled as above.
- Only one command outstanding. The next header is accepted only in IDLE; IDLE is not gated on the FIFO draining.
- mem_enable is one-hot or zero and is never asserted in IDLE.
- rsp_data, rsp_last and rsp_err hold stable while rsp_valid && !rsp_ready.
- Latency: header accepted at cycle N -> first read issue at N+1 -> rsp_valid at N+3 (capture at N+2, visible from FIFO at N+3).
- Reset asserted mid-burst: the burst is abandoned, no partial response is produced, and bank writes already performed are retained.

Optional Feature:
Macro TILE_MEM_NOC_ERR_EN.
- Defined: op 3 header -> one response {header[63:46], 46'b0} with rsp_err=1, rsp_last=1, then IDLE. Waits in IDLE-equivalent hold with cmd_ready=0 if the FIFO is full.
- Undefined: op 3 is treated as NOP (consumed, no response); rsp_err is tied to 0.

Test Plan:
- Reset then idle: all outputs 0, cmd_ready=1 one cycle after rst_n rises.
- WRITE bank2 W=5 LEN=1, data 64'hDEADBEEF_00000001 -> one cycle of mem_enable=4'b0100, mem_write_en=1, mem_addr=13'h028. Response is ack with rsp_last=1, rsp_err=0. Then READ of the same location returns 64'hDEADBEEF_00000001 with rsp_last=1.
- READ bank0 W=1022 LEN=4 with rsp_ready=1 -> mem_addr sequence 0x1FF0, 0x1FF8, 0x0000, 0x0008; 4 responses, rsp_last only on the 4th.
- READ LEN=16 with rsp_ready=0 for 20 cycles -> exactly RSP_DEPTH issues, then stall. Release rsp_ready -> all 16 words arrive in order, none lost or duplicated.
- WRITE LEN=3 with cmd_valid gaps between data beats -> writes only on transfer cycles, addresses consecutive, single ack.
- op=3 header: with TILE_MEM_NOC_ERR_EN -> rsp_err=1, rsp_last=1. Without the macro -> no response and the next command proceeds normally. Also assert rst_n low mid-burst -> outputs 0 immediately, no response on recovery.
